ula_serial: RTL and testbench
=============================

Name: ula_serial

Overview:
- Parametrised, nibble-serial successor to the 4-bit 74181-style ALU. Performs the full 74181 function set (16 logic plus 16 arithmetic functions) on WIDTH-bit operands.
- Runs one 4-bit slice per clock and ripples the carry through a register, so area stays at one slice for any width.
- Sits in the eight-bit-alu datapath behind a valid/ready handshake, between the operand register file and the result/flag writeback stage.

Parameters:
- WIDTH, 8, operand/result width; must be a multiple of 4 and >= 4. Elaboration error otherwise.
- NIB (localparam), WIDTH/4, number of slice passes per operation.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  4  function select (74181 encoding).
- m  in  1  1 = logic mode, 0 = arithmetic mode.
- c_in  in  1  carry in, active-low (0 adds 1).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- f  out  WIDTH  result.
- c_out  out  1  carry out of the MSB, active-high; 0 in logic mode.
- a_eq_b  out  1  full-width A == B for the accepted operands.
- zero  out  1  f == 0.

Behaviour:
- Reset (async, rst_n=0): state IDLE; in_ready=1; out_valid=0; f=0; c_out=0; a_eq_b=0; zero=0; all internal shift/carry registers cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch a, b, s, m, c_in into shift registers; carry register = ~c_in; nibble counter = 0; go to RUN.
  - RUN: in_ready=0. Each cycle, the slice computes nibble[cnt] from the low nibbles of the A/B shift registers and the carry register. The result nibble shifts in from the top of the F shift register, A/B shift right by 4, the carry register takes the slice cout, and cnt increments. After the pass with cnt == NIB-1, go to DONE.
  - DONE: out_valid=1; f, c_out, a_eq_b, zero stable. On out_valid&out_ready, go to IDLE.
- Outputs are registered; out_valid rises NIB cycles after the accept edge (WIDTH=8: 2 cycles).
- in_ready is asserted in IDLE only. There is no accept in the same cycle as the result handshake; in_valid outside IDLE is ignored.
- Arithmetic mode computes F = P + Q + carry, mod 2^WIDTH, with the carry chained across nibbles. P/Q by s:
  - 0000 A+0
  - 0001 (A|B)+0
  - 0010 (A|~B)+0
  - 0011 0+all-ones
  - 0100 A+(A&~B)
  - 0101 (A|B)+(A&~B)
  - 0110 A+~B
  - 0111 (A&~B)+all-ones
  - 1000 A+(A&B)
  - 1001 A+B
  - 1010 (A|~B)+(A&B)
  - 1011 (A&B)+all-ones
  - 1100 A+A
  - 1101 (A|B)+A
  - 1110 (A|~B)+A
  - 1111 A+all-ones
- c_out is the final carry register value.
- Logic mode is bitwise per 74181. Case 1100 yields all-ones. The carry chain is forced to 0, so c_out=0.
- a_eq_b is computed from the latched full-width operands and is independent of mode.
- zero is computed on the final f.
- Reset during RUN or DONE aborts the operation and discards the result; no partial out_valid.

Optional Feature:
- Macro ULA_SERIAL_OVF_EN.
- Defined: adds output v_out (1 bit), signed overflow in arithmetic mode = carry into MSB XOR carry out of MSB, captured on the last pass. v_out is 0 in logic mode and resets to 0.
- Undefined: port and logic are absent.

Decomposition:
- Package ula_pkg: state enum (IDLE, RUN, DONE); 4-bit localparams for the named s codes (e.g. S_ADD=1001, S_SUB=0110, S_DEC=1111).
- Sub-module ula_slice4: combinational 4-bit slice.
  - Inputs: a, b, s, m, cin (active-high).
  - Outputs: f[3:0], cout, plus c3 for overflow.
  - Instantiated once.

Test Plan:
- WIDTH=8, add with carry across nibbles: a=0x0F, b=0x01, s=1001, m=0, c_in=1 -> f=0x10, c_out=0, zero=0; out_valid exactly 2 cycles after accept.
- Subtract, no borrow: a=0x10, b=0x01, s=0110, m=0, c_in=0 -> f=0x0F, c_out=1. Subtract with borrow: a=0x01, b=0x02, same settings -> f=0xFF, c_out=0.
- Logic XOR plus equality: a=0xAA, b=0xAA, s=0110, m=1 -> f=0x00, zero=1, a_eq_b=1, c_out=0.
- WIDTH=16, increment wrap: a=0xFFFF, s=0000, m=0, c_in=0 -> f=0x0000, c_out=1, zero=1; latency 4 cycles.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> f and flags stable, in_ready=0, in_valid pulses ignored; result accepted on out_ready=1, then in_ready=1 next cycle.
- Reset mid-RUN: assert rst_n=0 during cycle 1 of an 8-bit operation -> all outputs 0 immediately; no out_valid; next accepted operation is correct.

Source files
------------

// File: rtl/ula_pkg.sv
// Shared types and function-select codes for the nibble-serial 74181-style ALU.
package ula_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Arithmetic-mode (m=0) function selects
    localparam logic [3:0] S_INC = 4'b0000;
    localparam logic [3:0] S_SUB = 4'b0110;
    localparam logic [3:0] S_ADD = 4'b1001;
    localparam logic [3:0] S_DBL = 4'b1100;
    localparam logic [3:0] S_DEC = 4'b1111;

    // Logic-mode (m=1) function selects
    localparam logic [3:0] S_XOR = 4'b0110;
    localparam logic [3:0] S_AND = 4'b1011;
    localparam logic [3:0] S_ONE = 4'b1100;

endpackage

// File: rtl/ula_slice4.sv
// Combinational 4-bit 74181 slice with active-high carry; c3 is the carry into bit 3.
module ula_slice4
    import ula_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       cout,
    output logic       c3
);

    logic [3:0] p;
    logic [3:0] q;
    logic [3:0] lf;
    logic [4:0] sum;
    logic [3:0] low;

    always_comb begin
        p = a;
        q = 4'h0;
        unique case (s)
            S_INC:   begin p = a;       q = 4'h0;    end
            4'b0001: begin p = a | b;   q = 4'h0;    end
            4'b0010: begin p = a | ~b;  q = 4'h0;    end
            4'b0011: begin p = 4'h0;    q = 4'hf;    end
            4'b0100: begin p = a;       q = a & ~b;  end
            4'b0101: begin p = a | b;   q = a & ~b;  end
            S_SUB:   begin p = a;       q = ~b;      end
            4'b0111: begin p = a & ~b;  q = 4'hf;    end
            4'b1000: begin p = a;       q = a & b;   end
            S_ADD:   begin p = a;       q = b;       end
            4'b1010: begin p = a | ~b;  q = a & b;   end
            4'b1011: begin p = a & b;   q = 4'hf;    end
            S_DBL:   begin p = a;       q = a;       end
            4'b1101: begin p = a | b;   q = a;       end
            4'b1110: begin p = a | ~b;  q = a;       end
            S_DEC:   begin p = a;       q = 4'hf;    end
            default: begin p = a;       q = 4'h0;    end
        endcase
    end

    always_comb begin
        lf = 4'h0;
        unique case (s)
            4'b0000: lf = ~a;
            4'b0001: lf = ~(a | b);
            4'b0010: lf = ~a & b;
            4'b0011: lf = 4'h0;
            4'b0100: lf = ~(a & b);
            4'b0101: lf = ~b;
            S_XOR:   lf = a ^ b;
            4'b0111: lf = a & ~b;
            4'b1000: lf = ~a | b;
            4'b1001: lf = ~(a ^ b);
            4'b1010: lf = b;
            S_AND:   lf = a & b;
            S_ONE:   lf = 4'hf;
            4'b1101: lf = a | ~b;
            4'b1110: lf = a | b;
            4'b1111: lf = a;
            default: lf = 4'h0;
        endcase
    end

    assign sum = {1'b0, p} + {1'b0, q} + {4'b0, cin};
    assign low = {1'b0, p[2:0]} + {1'b0, q[2:0]} + {3'b0, cin};

    // Logic mode breaks the carry chain entirely
    assign f    = m ? lf : sum[3:0];
    assign cout = m ? 1'b0 : sum[4];
    assign c3   = m ? 1'b0 : low[3];

endmodule

// File: rtl/ula_serial.sv
// Nibble-serial 74181-style ALU: one 4-bit slice per clock, carry rippled through a register.
// Define ULA_SERIAL_OVF_EN to add the signed-overflow output v_out.
module ula_serial
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             c_out,
    output logic             a_eq_b,
    output logic             zero
`ifdef ULA_SERIAL_OVF_EN
    ,
    output logic             v_out
`endif
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned CntW = (NIB > 1) ? $clog2(NIB) : 1;

    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
        $error("ula_serial: WIDTH must be a multiple of 4 and >= 4");
    end

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, f_q, f_d;
    logic [3:0]        s_q, s_d;
    logic              m_q, m_d, carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              c_out_q, c_out_d, a_eq_b_q, a_eq_b_d, zero_q, zero_d, v_q, v_d;
    logic [3:0]        sl_f;
    logic              sl_cout, sl_c3;
    logic [WIDTH+3:0]  f_cat;

    ula_slice4 u_slice (
        .a    (a_q[3:0]),
        .b    (b_q[3:0]),
        .s    (s_q),
        .m    (m_q),
        .cin  (carry_q),
        .f    (sl_f),
        .cout (sl_cout),
        .c3   (sl_c3)
    );

    // New nibble enters at the top so the first pass ends up in f[3:0]
    assign f_cat = {sl_f, f_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        f_d      = f_q;
        s_d      = s_q;
        m_d      = m_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        c_out_d  = c_out_q;
        a_eq_b_d = a_eq_b_q;
        zero_d   = zero_q;
        v_d      = v_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d      = a;
                    b_d      = b;
                    s_d      = s;
                    m_d      = m;
                    carry_d  = ~c_in;
                    cnt_d    = '0;
                    a_eq_b_d = (a == b);
                    state_d  = StRun;
                end
            end
            StRun: begin
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                f_d     = f_cat[WIDTH+3:4];
                carry_d = sl_cout;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CntW'(NIB - 1)) begin
                    c_out_d = sl_cout;
                    zero_d  = (f_d == '0);
                    v_d     = sl_c3 ^ sl_cout;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            f_q      <= '0;
            s_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            c_out_q  <= 1'b0;
            a_eq_b_q <= 1'b0;
            zero_q   <= 1'b0;
            v_q      <= 1'b0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            f_q      <= f_d;
            s_q      <= s_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            c_out_q  <= c_out_d;
            a_eq_b_q <= a_eq_b_d;
            zero_q   <= zero_d;
            v_q      <= v_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign f         = f_q;
    assign c_out     = c_out_q;
    assign a_eq_b    = a_eq_b_q;
    assign zero      = zero_q;

`ifdef ULA_SERIAL_OVF_EN
    assign v_out = v_q;
`else
    logic unused_v;
    assign unused_v = v_q;
`endif

endmodule

// File: tb/tb_ula_serial.sv
// Directed self-checking bench for ula_serial at WIDTH=8 and WIDTH=16.
module tb_ula_serial;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        in_valid, in_ready, m, c_in, out_valid, out_ready, c_out, a_eq_b, zero;
    logic [7:0]  a, b, f;
    logic [3:0]  s;

    logic        in_valid16, in_ready16, m16, c_in16, out_valid16, out_ready16;
    logic        c_out16, a_eq_b16, zero16;
    logic [15:0] a16, b16, f16;
    logic [3:0]  s16;

`ifdef ULA_SERIAL_OVF_EN
    logic        v_out, v_out16;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ula_serial #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .s         (s),
        .m         (m),
        .c_in      (c_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .f         (f),
        .c_out     (c_out),
        .a_eq_b    (a_eq_b),
        .zero      (zero)
`ifdef ULA_SERIAL_OVF_EN
        ,
        .v_out     (v_out)
`endif
    );

    ula_serial #(.WIDTH(16)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid16),
        .in_ready  (in_ready16),
        .a         (a16),
        .b         (b16),
        .s         (s16),
        .m         (m16),
        .c_in      (c_in16),
        .out_valid (out_valid16),
        .out_ready (out_ready16),
        .f         (f16),
        .c_out     (c_out16),
        .a_eq_b    (a_eq_b16),
        .zero      (zero16)
`ifdef ULA_SERIAL_OVF_EN
        ,
        .v_out     (v_out16)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one 8-bit operation and wait (bounded) for out_valid; lat = cycles after accept.
    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic [3:0] ts,
                        input logic tm, input logic tc, output int lat);
        @(negedge clk);
        a = ta; b = tb; s = ts; m = tm; c_in = tc; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
    endtask

    task automatic release8();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                       input logic [3:0] ts, input logic tm, input logic tc,
                       input logic [7:0] ef, input logic ec, input logic ez, input logic ee);
        int lat;
        run8(ta, tb, ts, tm, tc, lat);
        check({tag, ".lat"}, lat, 2);
        check({tag, ".f"}, f, ef);
        check({tag, ".c_out"}, c_out, ec);
        check({tag, ".zero"}, zero, ez);
        check({tag, ".a_eq_b"}, a_eq_b, ee);
        release8();
        check({tag, ".in_ready"}, in_ready, 1'b1);
        check({tag, ".ov_clr"}, out_valid, 1'b0);
    endtask

    initial begin
        logic [7:0] hold_f;
        int         lat;

        in_valid = 0; out_ready = 0; a = 0; b = 0; s = 0; m = 0; c_in = 1;
        in_valid16 = 0; out_ready16 = 0; a16 = 0; b16 = 0; s16 = 0; m16 = 0; c_in16 = 1;

        #12;
        check("rst.in_ready", in_ready, 1'b1);
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.f", f, 8'h00);
        check("rst.flags", {c_out, a_eq_b, zero}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;

        //    tag     a      b      s        m  c_in  f      c  z  eq
        op8("add",   8'h0F, 8'h01, 4'b1001, 0, 1,    8'h10, 0, 0, 0);
        op8("sub",   8'h10, 8'h01, 4'b0110, 0, 0,    8'h0F, 1, 0, 0);
        op8("borrow", 8'h01, 8'h02, 4'b0110, 0, 0,   8'hFF, 0, 0, 0);
        op8("xor",   8'hAA, 8'hAA, 4'b0110, 1, 1,    8'h00, 0, 1, 1);
        op8("dec",   8'h05, 8'h33, 4'b1111, 0, 1,    8'h04, 1, 0, 0);
        op8("dbl",   8'h81, 8'h00, 4'b1100, 0, 1,    8'h02, 1, 0, 0);
        op8("ones",  8'h12, 8'h34, 4'b1100, 1, 0,    8'hFF, 0, 0, 0);
        op8("and",   8'hF0, 8'h3C, 4'b1011, 1, 0,    8'h30, 0, 0, 0);

        // Back-pressure: result must hold while out_ready is low; in_valid ignored
        run8(8'h12, 8'h34, 4'b1001, 1'b0, 1'b1, lat);
        check("bp.f0", f, 8'h46);
        hold_f = 8'h46;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; a = 8'hFF; b = 8'h01;
            check("bp.f", f, hold_f);
            check("bp.in_ready", in_ready, 1'b0);
            check("bp.out_valid", out_valid, 1'b1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("bp.f_end", f, 8'h46);
        release8();
        check("bp.in_ready_after", in_ready, 1'b1);
        check("bp.f_kept", f, 8'h46);

        // Reset one cycle into RUN aborts without a partial result
        @(negedge clk);
        a = 8'h0F; b = 8'h01; s = 4'b1001; m = 0; c_in = 1; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid.f", f, 8'h00);
        check("mid.out_valid", out_valid, 1'b0);
        check("mid.in_ready", in_ready, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid.no_valid", out_valid, 1'b0);
        end
        rst_n = 1'b1;
        op8("after", 8'h27, 8'h19, 4'b1001, 0, 1, 8'h40, 0, 0, 0);

        // WIDTH=16 increment wrap, 4-cycle latency
        @(negedge clk);
        a16 = 16'hFFFF; b16 = 16'h0000; s16 = 4'b0000; m16 = 0; c_in16 = 0; in_valid16 = 1'b1;
        @(posedge clk);
        #1 in_valid16 = 1'b0;
        lat = 0;
        while (!out_valid16 && lat < 20) begin
            @(posedge clk);
            #1 lat++;
        end
        check("w16.lat", lat, 4);
        check("w16.f", f16, 16'h0000);
        check("w16.c_out", c_out16, 1'b1);
        check("w16.zero", zero16, 1'b1);
        check("w16.a_eq_b", a_eq_b16, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
